sync_fifo: RTL and testbench

//   Single-clock FIFO built on a 2^ASIZE x WSIZE register array. It adds the

---
 rtl/sync_fifo.sv | 123 ++++++++++++
 tb/tb_sync_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array storage with pointers, occupancy count,
// almost-flags, sticky overflow/underflow and registered or FWFT read.
module sync_fifo #(
    parameter int ASIZE     = 4,
    parameter int WSIZE     = 8,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WSIZE-1:0] wdata,
    input  logic             ren,
    output logic [WSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   count,
    output logic             ovf,
    output logic             udf
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] ONE_C     = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] ZERO_C    = {(ASIZE+1){1'b0}};
    localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C  = (ASIZE+1)'(AEMPTY_TH);

    logic [WSIZE-1:0] mem_r [DEPTH];
    logic [ASIZE:0]   wptr_r, rptr_r, count_r;
    logic             full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
    logic             wacc_s, racc_s;
    logic [ASIZE:0]   wptr_nxt_s, rptr_nxt_s, count_nxt_s;

    // Acceptance uses the registered flags only, so a same-cycle read never frees space for a write.
    always_comb begin
        wacc_s      = wen && !full_r;
        racc_s      = ren && !empty_r;
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        if (wacc_s) begin
            wptr_nxt_s = wptr_r + ONE_C;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (racc_s) begin
            rptr_nxt_s = rptr_r + ONE_C;
        end else begin
            rptr_nxt_s = rptr_r;
        end
        count_nxt_s = wptr_nxt_s - rptr_nxt_s;
    end

    // Pointer, occupancy and flag registers; flags are precomputed from next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r   <= ZERO_C;
            rptr_r   <= ZERO_C;
            count_r  <= ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wptr_r   <= wptr_nxt_s;
            rptr_r   <= rptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == ZERO_C);
            afull_r  <= (count_nxt_s >= AFULL_C);
            aempty_r <= (count_nxt_s <= AEMPTY_C);
            ovf_r    <= ovf_r | (wen & full_r);
            udf_r    <= udf_r | (ren & empty_r);
        end
    end

    // Storage write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wacc_s && !rst) begin
            mem_r[wptr_r[ASIZE-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WSIZE-1:0] rdata_r;
            logic             rvalid_r;

            // Registered read: data and valid appear one edge after an accepted pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_r  <= {WSIZE{1'b0}};
                    rvalid_r <= 1'b0;
                end else if (racc_s) begin
                    rdata_r  <= mem_r[rptr_r[ASIZE-1:0]];
                    rvalid_r <= 1'b1;
                end else begin
                    rvalid_r <= 1'b0;
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
        end else begin : g_fwft_read
            // Head word is shown directly; ren acknowledges it.
            assign rdata  = mem_r[rptr_r[ASIZE-1:0]];
            assign rvalid = !empty_r;
        end
    endgenerate

    assign full   = full_r;
    assign empty  = empty_r;
    assign afull  = afull_r;
    assign aempty = aempty_r;
    assign count  = count_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue scoreboard against a registered-read
// instance, plus a first-word-fall-through instance.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wen = 1'b0, ren = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       rvalid, full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    logic       wen2 = 1'b0, ren2 = 1'b0;
    logic [7:0] wdata2 = 8'h00;
    logic [7:0] rdata2;
    logic       rvalid2, full2, empty2, afull2, aempty2, ovf2, udf2;
    logic [4:0] count2;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         mcount = 0;
    logic       m_ovf = 1'b0, m_udf = 1'b0, m_rvalid = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    always #5 clk = ~clk;

    sync_fifo #(.ASIZE(4), .WSIZE(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .afull(afull), .aempty(aempty), .count(count), .ovf(ovf), .udf(udf));

    sync_fifo #(.ASIZE(4), .WSIZE(8), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wen(wen2), .wdata(wdata2), .ren(ren2),
        .rdata(rdata2), .rvalid(rvalid2), .full(full2), .empty(empty2),
        .afull(afull2), .aempty(aempty2), .count(count2), .ovf(ovf2), .udf(udf2));

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mcount = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0;
    endtask

    // One clock on the registered-read instance; the model decides acceptance from pre-edge state.
    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        logic wacc, racc;
        wen = w; wdata = d; ren = r;
        wacc = w && (mcount < 16);
        racc = r && (mcount > 0);
        if (racc) exp_rd = exp_q.pop_front();
        if (wacc) exp_q.push_back(d);
        if (w && !wacc) m_ovf = 1'b1;
        if (r && mcount == 0) m_udf = 1'b1;
        mcount = mcount + int'(wacc) - int'(racc);
        m_rvalid = racc;
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({empty, full, aempty, afull} !== 4'b1010) begin failures++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, aempty, afull}); end
        checks++; if ({ovf, udf, rvalid} !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", {ovf, udf, rvalid}); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            checks++; if (count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            checks++; if (afull !== (i + 1 >= 14)) begin failures++; $display("FAIL fill_afull got=%b at count=%0d", afull, i + 1); end
            checks++; if (aempty !== (i + 1 <= 2)) begin failures++; $display("FAIL fill_aempty got=%b at count=%0d", aempty, i + 1); end
            checks++; if (full !== (i == 15)) begin failures++; $display("FAIL fill_full got=%b at count=%0d", full, i + 1); end
            checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", empty); end
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 8'hAA, 1'b0);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL drain_rvalid got=%b exp=1", rvalid); end
            checks++; if (rdata !== 8'(i)) begin failures++; $display("FAIL drain_data got=%0h exp=%0h", rdata, i); end
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (udf !== 1'b1) begin failures++; $display("FAIL udf_set got=%b exp=1", udf); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL udf_rvalid got=%b exp=0", rvalid); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0);
        tick(1'b1, 8'h50, 1'b1);
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL simul5_count got=%0d exp=5", count); end
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h10) begin failures++; $display("FAIL simul5_data got=%b/%0h exp=1/10", rvalid, rdata); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            checks++; if (rdata !== exp_rd || rvalid !== 1'b1) begin failures++; $display("FAIL simul5_order got=%0h exp=%0h", rdata, exp_rd); end
        end
        checks++; if (exp_rd !== 8'h50 || ovf !== 1'b0) begin failures++; $display("FAIL simul5_tail got=%0h/%b exp=50/0", exp_rd, ovf); end
        for (int i = 0; i < 16; i++) tick(1'b1, 8'h80 + 8'(i), 1'b0);
        tick(1'b1, 8'h77, 1'b1);
        checks++; if (count !== 5'd15 || full !== 1'b0) begin failures++; $display("FAIL simul16_count got=%0d/%b exp=15/0", count, full); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL simul16_ovf got=%b exp=1", ovf); end
        checks++; if (rdata !== 8'h80 || rvalid !== 1'b1) begin failures++; $display("FAIL simul16_data got=%0h exp=80", rdata); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            checks++; if (count !== 5'(mcount)) begin failures++; $display("FAIL rand_count step=%0d got=%0d exp=%0d", i, count, mcount); end
            checks++; if (rvalid !== m_rvalid) begin failures++; $display("FAIL rand_rvalid step=%0d got=%b exp=%b", i, rvalid, m_rvalid); end
            if (m_rvalid) begin
                checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rand_data step=%0d got=%0h exp=%0h", i, rdata, exp_rd); end
            end
            checks++; if (full !== (mcount == 16) || empty !== (mcount == 0)) begin failures++; $display("FAIL rand_flags step=%0d got=%b%b count=%0d", i, full, empty, mcount); end
        end
        checks++; if (ovf !== m_ovf || udf !== m_udf) begin failures++; $display("FAIL rand_sticky got=%b%b exp=%b%b", ovf, udf, m_ovf, m_udf); end
    endtask

    task automatic test_fwft();
        do_reset();
        checks++; if (rvalid2 !== 1'b0 || empty2 !== 1'b1) begin failures++; $display("FAIL fwft_reset got=%b/%b exp=0/1", rvalid2, empty2); end
        wen2 = 1'b1; wdata2 = 8'h5A;
        @(posedge clk); #1;
        wen2 = 1'b0;
        checks++; if (rdata2 !== 8'h5A || rvalid2 !== 1'b1) begin failures++; $display("FAIL fwft_first got=%0h/%b exp=5a/1", rdata2, rvalid2); end
        wen2 = 1'b1; wdata2 = 8'h5B; @(posedge clk); #1;
        wdata2 = 8'h5C; @(posedge clk); #1;
        wen2 = 1'b0; ren2 = 1'b1; @(posedge clk); #1;
        ren2 = 1'b0;
        checks++; if (rdata2 !== 8'h5B || count2 !== 5'd2) begin failures++; $display("FAIL fwft_pop got=%0h/%0d exp=5b/2", rdata2, count2); end
        wen2 = 1'b1; wdata2 = 8'h5D; @(posedge clk); #1;
        wen2 = 1'b0;
        checks++; if (count2 !== 5'd3) begin failures++; $display("FAIL fwft_hold3 got=%0d exp=3", count2); end
        do_reset();
        checks++; if (empty2 !== 1'b1 || rvalid2 !== 1'b0 || count2 !== 5'd0) begin failures++; $display("FAIL fwft_rst got=%b/%b/%0d exp=1/0/0", empty2, rvalid2, count2); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_random();
        test_fwft();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
